data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `DataMemory`. It shares the memory between port 0 (core load/store unit) and port 1 (debug/IO loader). Each access runs as a registered three-phase transaction (grant, access, response). Sizes and sign extension are passed through unchanged on the existing `mem_data_size` encoding.

---
 rtl/data_mem_arbiter_pkg.sv | 39 +++
 rtl/data_mem_arbiter_rr_pick2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// access-size codes and the layout of the latched transaction register.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // One granted request as held for the duration of a transaction.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  size;
    } txn_t;

    // True when the access cannot be issued as-is: a halfword on an odd
    // address, a word not on a 4-byte boundary, or an undefined size code.
    function automatic logic misaligned(input logic [1:0] addr_lo,
                                        input logic [2:0] size);
        logic bad;
        case (size)
            SZ_B, SZ_BU: bad = 1'b0;
            SZ_H, SZ_HU: bad = addr_lo[0];
            SZ_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-requester picker: round-robin on ties, or fixed priority to
// requester 0 when fixed_prio is set. Purely combinational.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic fixed_prio,
    output logic gnt_valid,
    output logic gnt_id
);

    // On a tie pick the requester that was not granted last (or 0 under
    // fixed priority); otherwise the single requester wins.
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = fixed_prio ? 1'b0 : ~last_gnt;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port DataMemory.
// Each access is a registered IDLE -> ACCESS -> RESP transaction.
// Optional feature macro: DMEM_ALIGN_CHECK_EN rejects misaligned or
// illegal-size requests straight to RESP with pN_err set.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        busy,

    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_in,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [2:0]  mem_data_size,
    input  logic [31:0] mem_out
);

    state_e      state_q;
    logic        last_gnt_q;
    logic        gnt_id_q;
    txn_t        txn_q;
    logic        ack0_q, ack1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        gnt_valid;
    logic        gnt_id;
    txn_t        txn_d;
    logic        reject_d;

    rr_pick2 u_pick (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_gnt   (last_gnt_q),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Select the winning port's fields and decide whether it must be rejected.
    always_comb begin
        if (gnt_id) begin
            txn_d = '{addr: p1_addr, wdata: p1_wdata, we: p1_we, size: p1_size};
        end else begin
            txn_d = '{addr: p0_addr, wdata: p0_wdata, we: p0_we, size: p0_size};
        end
`ifdef DMEM_ALIGN_CHECK_EN
        reject_d = misaligned(txn_d.addr[1:0], txn_d.size);
`else
        reject_d = 1'b0;
`endif
    end

    // Transaction FSM: grant/latch in IDLE, one memory cycle, one ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            txn_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        txn_q      <= txn_d;
                        gnt_id_q   <= gnt_id;
                        last_gnt_q <= gnt_id;
                        if (reject_d) begin
                            // Skip the memory cycle entirely; respond with err.
                            state_q <= RESP;
                            ack0_q  <= ~gnt_id;
                            ack1_q  <= gnt_id;
                            err0_q  <= ~gnt_id;
                            err1_q  <= gnt_id;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Store commits at this edge; a load captures mem_out.
                    state_q <= RESP;
                    if (gnt_id_q) begin
                        ack1_q   <= 1'b1;
                        rdata1_q <= txn_q.we ? 32'd0 : mem_out;
                    end else begin
                        ack0_q   <= 1'b1;
                        rdata0_q <= txn_q.we ? 32'd0 : mem_out;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory side is live only during ACCESS, straight from the latched request,
    // so an asynchronous reset removes the write enable immediately.
    always_comb begin
        busy            = (state_q != IDLE);
        mem_access_addr = '0;
        mem_in          = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        mem_data_size   = '0;
        if (state_q == ACCESS) begin
            mem_access_addr = txn_q.addr;
            mem_in          = txn_q.wdata;
            mem_write_en    = txn_q.we;
            mem_read_en     = ~txn_q.we;
            mem_data_size   = txn_q.size;
        end
    end

    assign p0_ack   = ack0_q;
    assign p1_ack   = ack1_q;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;
    assign p0_err   = err0_q;
    assign p1_err   = err1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural DataMemory model
// and a scoreboard of expected responses in grant order.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic [2:0]  p0_size = '0, p1_size = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err, busy;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_access_addr, mem_in, mem_out;
    logic        mem_write_en, mem_read_en;
    logic [2:0]  mem_data_size;

    logic        fp_p0_req = 1'b0, fp_p1_req = 1'b0;
    logic        fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err, fp_busy;
    logic [31:0] fp_p0_rdata, fp_p1_rdata;
    logic [31:0] fp_mem_access_addr, fp_mem_in, fp_mem_out;
    logic        fp_mem_write_en, fp_mem_read_en;
    logic [2:0]  fp_mem_data_size;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int p0_ack_cnt = 0;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_size(p0_size), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_size(p1_size), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .busy(busy),
        .mem_access_addr(mem_access_addr), .mem_in(mem_in),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_data_size(mem_data_size), .mem_out(mem_out)
    );

    data_mem_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .p0_req(fp_p0_req), .p0_addr(32'h100), .p0_wdata(32'h0), .p0_we(1'b0),
        .p0_size(3'b010), .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata), .p0_err(fp_p0_err),
        .p1_req(fp_p1_req), .p1_addr(32'h200), .p1_wdata(32'h0), .p1_we(1'b0),
        .p1_size(3'b010), .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata), .p1_err(fp_p1_err),
        .busy(fp_busy),
        .mem_access_addr(fp_mem_access_addr), .mem_in(fp_mem_in),
        .mem_write_en(fp_mem_write_en), .mem_read_en(fp_mem_read_en),
        .mem_data_size(fp_mem_data_size), .mem_out(fp_mem_out)
    );

    // Simple read source for the fixed-priority instance: tags size and address.
    assign fp_mem_out = fp_mem_read_en ? {fp_mem_data_size, 5'd0, fp_mem_access_addr[23:0]} : 32'h0;

    // Behavioural DataMemory: 256 bytes, little-endian, low address bits dropped.
    logic [7:0] mem [0:255];
    logic [7:0] a, ah, aw;

    always @(posedge clk) begin
        if (mem_write_en) begin
            case (mem_data_size)
                3'b000, 3'b100: mem[a] <= mem_in[7:0];
                3'b001, 3'b101: begin
                    mem[ah]      <= mem_in[7:0];
                    mem[ah + 1]  <= mem_in[15:8];
                end
                default: begin
                    mem[aw]      <= mem_in[7:0];
                    mem[aw + 1]  <= mem_in[15:8];
                    mem[aw + 2]  <= mem_in[23:16];
                    mem[aw + 3]  <= mem_in[31:24];
                end
            endcase
        end
    end

    always_comb begin
        a  = mem_access_addr[7:0];
        ah = {a[7:1], 1'b0};
        aw = {a[7:2], 2'b00};
        case (mem_data_size)
            3'b000:  mem_out = {{24{mem[a][7]}}, mem[a]};
            3'b100:  mem_out = {24'd0, mem[a]};
            3'b001:  mem_out = {{16{mem[ah + 1][7]}}, mem[ah + 1], mem[ah]};
            3'b101:  mem_out = {16'd0, mem[ah + 1], mem[ah]};
            default: mem_out = {mem[aw + 3], mem[aw + 2], mem[aw + 1], mem[aw]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: count enable cycles and pop the scoreboard on every ack.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write_en) we_cnt++;
            if (mem_read_en) re_cnt++;
            if (mem_write_en || mem_read_en)
                chk("we_re_exclusive", {31'd0, mem_write_en & mem_read_en}, 32'd0);
            if (p0_ack) p0_ack_cnt++;
            if (p0_ack || p1_ack) begin
                chk("single_ack", {31'd0, p0_ack & p1_ack}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed=ack expected=none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_port", {31'd0, p1_ack}, {31'd0, e.id});
                    chk("sb_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
                    chk("sb_err", {31'd0, p1_ack ? p1_err : p0_err}, {31'd0, e.err});
                    chk("idle_port_rdata", p1_ack ? p0_rdata : p1_rdata, 32'd0);
                end
            end
        end
    end

    task automatic do_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit we, input logic [2:0] size, input logic [31:0] exp_rd,
                          input bit exp_err, input int exp_lat);
        int  lat;
        bit  done;
        @(posedge clk);
        #1;
        if (port) begin
            p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_size = size; p1_req = 1'b1;
        end else begin
            p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_size = size; p0_req = 1'b1;
        end
        sb.push_back('{id: port, rdata: exp_rd, err: exp_err});
        lat = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (port ? p1_ack : p0_ack) done = 1'b1;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("ack_seen", {31'd0, done}, 32'd1);
        chk("latency", lat, exp_lat);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n, last_i, we0, re0, ack0;

        // Reset state, before any clock edge.
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        chk("rst_mem_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("rst_mem_addr", mem_access_addr, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Port 0 word store then load.
        we0 = we_cnt;
        do_req(0, 32'h40, 32'hDEADBEEF, 1, 3'b010, 32'h0, 0, 3);
        chk("store_we_cycles", we_cnt - we0, 1);
        we0 = we_cnt; re0 = re_cnt;
        do_req(0, 32'h40, 32'h0, 0, 3'b010, 32'hDEADBEEF, 0, 3);
        chk("load_re_cycles", re_cnt - re0, 1);
        chk("load_we_cycles", we_cnt - we0, 0);

        // Preload for later steps.
        do_req(1, 32'h44, 32'hCAFEF00D, 1, 3'b010, 32'h0, 0, 3);
        do_req(0, 32'h20, 32'h1234ABCD, 1, 3'b010, 32'h0, 0, 3);
        do_req(0, 32'h10, 32'h11223344, 1, 3'b010, 32'h0, 0, 3);

        // Simultaneous continuous requests right after reset: 0,1,0,1,0,1.
        pulse_reset();
        @(posedge clk);
        #1;
        p0_addr = 32'h40; p0_we = 1'b0; p0_size = 3'b010;
        p1_addr = 32'h44; p1_we = 1'b0; p1_size = 3'b010;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{id: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
            sb.push_back('{id: 1'b1, rdata: 32'hCAFEF00D, err: 1'b0});
        end
        p0_req = 1'b1; p1_req = 1'b1;
        n = 0; last_i = -1;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                chk("alt_gap", i - last_i, 3);
                last_i = i;
                n++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("alt_count", n, 6);

        // Fixed priority: port 0 every 3 cycles, port 1 starved.
        @(posedge clk);
        #1;
        fp_p0_req = 1'b1; fp_p1_req = 1'b1;
        n = 0; last_i = -1;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(negedge clk);
            chk("fp_p1_ack", {31'd0, fp_p1_ack}, 32'd0);
            chk("fp_no_write", {31'd0, fp_mem_write_en}, 32'd0);
            if (fp_p0_ack) begin
                chk("fp_rdata", fp_p0_rdata, 32'h40000100);
                chk("fp_gap", i - last_i, 3);
                chk("fp_err", {30'd0, fp_p0_err, fp_p1_err}, 32'd0);
                chk("fp_p1_rdata", fp_p1_rdata, 32'd0);
                chk("fp_mem_in", fp_mem_in, 32'd0);
                last_i = i;
                n++;
            end
        end
        fp_p0_req = 1'b0; fp_p1_req = 1'b0;
        chk("fp_count", n, 10);
        repeat (3) @(negedge clk);
        chk("fp_idle", {31'd0, fp_busy}, 32'd0);

        // Port 1 byte store, signed and unsigned byte loads.
        ack0 = p0_ack_cnt;
        do_req(1, 32'h43, 32'h00000080, 1, 3'b000, 32'h0, 0, 3);
        do_req(1, 32'h43, 32'h0, 0, 3'b000, 32'hFFFFFF80, 0, 3);
        do_req(1, 32'h43, 32'h0, 0, 3'b100, 32'h00000080, 0, 3);
        chk("p0_ack_quiet", p0_ack_cnt - ack0, 0);

        // Reset in the middle of a store's ACCESS cycle aborts it.
        @(posedge clk);
        #1;
        p0_addr = 32'h10; p0_wdata = 32'h12345678; p0_we = 1'b1; p0_size = 3'b010; p0_req = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_we_high", {31'd0, mem_write_en}, 32'd1);
        we0 = we_cnt;
        reset = 1'b1;
        #1;
        chk("abort_we", {31'd0, mem_write_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        p0_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        end
        chk("abort_we_cycles", we_cnt - we0, 0);
        do_req(0, 32'h10, 32'h0, 0, 3'b010, 32'h11223344, 0, 3);

        // Misaligned halfword load.
        re0 = re_cnt;
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(0, 32'h21, 32'h0, 0, 3'b001, 32'h0, 1, 2);
        chk("misalign_no_read", re_cnt - re0, 0);
`else
        do_req(0, 32'h21, 32'h0, 0, 3'b001, 32'hFFFFABCD, 0, 3);
        chk("misalign_read", re_cnt - re0, 1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
